// File: rtl/varredura_colisao.sv
// varredura_colisao: sequential enemy-slot collision sweep with kill handshake, ship-hit flag and score.
module varredura_colisao #(
    parameter int N_INIMIGOS   = 20,
    parameter int LARG_INIMIGO = 20,
    parameter int ALT_INIMIGO  = 16,
    parameter int LARG_BOLA    = 4,
    parameter int LARG_NAVE    = 30,
    parameter int ALT_NAVE     = 16,
    parameter int PONTOS_KILL  = 10
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      reiniciarJogo,
    input  logic                      pausa,
    input  logic                      inicio_varredura,
    input  logic [10*N_INIMIGOS-1:0]  reg_inimigo_x,
    input  logic [10*N_INIMIGOS-1:0]  reg_inimigo_y,
    input  logic [10*N_INIMIGOS-1:0]  reg_x_bola,
    input  logic [10*N_INIMIGOS-1:0]  reg_y_bola,
    input  logic [0:N_INIMIGOS-1]     reg_vivo,
    input  logic [9:0]                bola_nave_x,
    input  logic [9:0]                bola_nave_y,
    input  logic                      bola_nave_ativa,
    input  logic [9:0]                x_nave,
    input  logic [9:0]                y_nave,
    input  logic                      acerto_ack,
    output logic                      acerto_valido,
    output logic [4:0]                acerto_indice,
    output logic                      nave_atingida,
    output logic                      varredura_fim,
    output logic                      ocupado,
    output logic [15:0]               pontos
);
    typedef enum logic [1:0] {OCIOSO, VARRE, ESPERA_ACK, FIM} estado_t;
    estado_t estado, prox;
    logic [4:0] idx;
    logic [9:0] bx, by, nx, ny, ex, ey, ebx, eby;
    logic [7:0] base;
    logic ativa, ja_acertou, hit_nave, kill, tiro_nave, ultimo, limpa;
    logic [16:0] soma;

    // 11-bit compare so boxes near 1023 do not wrap
    function automatic logic sobrepoe(input logic [9:0] ax, ay, bx_, by_, input logic [10:0] aw, ah, bw, bh);
        return ({1'b0, ax} < {1'b0, bx_} + bw) && ({1'b0, bx_} < {1'b0, ax} + aw) &&
               ({1'b0, ay} < {1'b0, by_} + bh) && ({1'b0, by_} < {1'b0, ay} + ah);
    endfunction

    always_comb begin
        base = 8'(idx) * 8'd10;
        ex = reg_inimigo_x[base +: 10];
        ey = reg_inimigo_y[base +: 10];
        ebx = reg_x_bola[base +: 10];
        eby = reg_y_bola[base +: 10];
        ultimo = idx == 5'(N_INIMIGOS - 1);
        tiro_nave = (eby != 10'd0) && sobrepoe(ebx, eby, nx, ny, 11'(LARG_BOLA), 11'(LARG_BOLA), 11'(LARG_NAVE), 11'(ALT_NAVE));
        kill = reg_vivo[idx] && ativa && !ja_acertou &&
               sobrepoe(bx, by, ex, ey, 11'(LARG_BOLA), 11'(LARG_BOLA), 11'(LARG_INIMIGO), 11'(ALT_INIMIGO));
        soma = {1'b0, pontos} + 17'(PONTOS_KILL);
        limpa = reset || reiniciarJogo;
        ocupado = estado != OCIOSO;
        prox = estado;
        case (estado)
            OCIOSO:     prox = (inicio_varredura && !pausa) ? VARRE : OCIOSO;
            VARRE:      prox = pausa ? VARRE : kill ? ESPERA_ACK : ultimo ? FIM : VARRE;
            ESPERA_ACK: prox = !acerto_ack ? ESPERA_ACK : ultimo ? FIM : VARRE;
            default:    prox = OCIOSO;
        endcase
    end

    always_ff @(posedge CLOCK_50)
        estado <= limpa ? OCIOSO : prox;

    always_ff @(posedge CLOCK_50) begin
        if (limpa) begin
            idx <= '0;
            {bx, by, nx, ny} <= '0;
            {ativa, ja_acertou, hit_nave} <= '0;
            {acerto_valido, nave_atingida, varredura_fim} <= '0;
            acerto_indice <= '0;
            pontos <= '0;
        end else begin
            varredura_fim <= 1'b0;
            nave_atingida <= 1'b0;
            case (estado)
                OCIOSO: if (inicio_varredura && !pausa) begin
                    {bx, by, ativa, nx, ny} <= {bola_nave_x, bola_nave_y, bola_nave_ativa, x_nave, y_nave};
                    idx <= '0;
                    ja_acertou <= 1'b0;
                    hit_nave <= 1'b0;
                end
                VARRE: if (!pausa) begin
                    if (tiro_nave) hit_nave <= 1'b1;
                    if (kill) begin
                        acerto_indice <= idx;
                        acerto_valido <= 1'b1;
                    end else if (!ultimo) idx <= idx + 5'd1;
                end
                ESPERA_ACK: if (acerto_ack) begin
                    acerto_valido <= 1'b0;
                    ja_acertou <= 1'b1;
                    pontos <= soma[16] ? 16'hFFFF : soma[15:0];
                    if (!ultimo) idx <= idx + 5'd1;
                end
                default: begin
                    varredura_fim <= 1'b1;
                    nave_atingida <= hit_nave;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_varredura_colisao.sv
// tb_varredura_colisao: directed checks of sweep latency, kill handshake, ship hits and score.
module tb_varredura_colisao;
    logic CLOCK_50 = 0, reset = 1, reiniciarJogo = 0, pausa = 0, inicio_varredura = 0;
    logic [199:0] reg_inimigo_x = '0, reg_inimigo_y = '0, reg_x_bola = '0, reg_y_bola = '0;
    logic [0:19] reg_vivo = '0;
    logic [9:0] bola_nave_x = 0, bola_nave_y = 0, x_nave = 10'd500, y_nave = 10'd400;
    logic bola_nave_ativa = 0, acerto_ack = 0;
    logic acerto_valido, nave_atingida, varredura_fim, ocupado;
    logic [4:0] acerto_indice;
    logic [15:0] pontos;
    int cyc = 0, n_checks = 0, n_erros = 0;
    int lat, nk, fi;
    bit ns;

    varredura_colisao dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .reiniciarJogo(reiniciarJogo), .pausa(pausa),
        .inicio_varredura(inicio_varredura), .reg_inimigo_x(reg_inimigo_x), .reg_inimigo_y(reg_inimigo_y),
        .reg_x_bola(reg_x_bola), .reg_y_bola(reg_y_bola), .reg_vivo(reg_vivo),
        .bola_nave_x(bola_nave_x), .bola_nave_y(bola_nave_y), .bola_nave_ativa(bola_nave_ativa),
        .x_nave(x_nave), .y_nave(y_nave), .acerto_ack(acerto_ack), .acerto_valido(acerto_valido),
        .acerto_indice(acerto_indice), .nave_atingida(nave_atingida), .varredura_fim(varredura_fim),
        .ocupado(ocupado), .pontos(pontos)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic set_inimigo(input int i, input int x, input int y);
        reg_inimigo_x[10*i +: 10] = 10'(x);
        reg_inimigo_y[10*i +: 10] = 10'(y);
    endtask

    // Pulses start, then watches one sweep; pause/inicio pulses are placed relative to the start edge
    task automatic varre(input int ack_delay, input int pausa_em, input int pausa_len, input int inicio_em,
                         output int l, output int kills, output int idx1, output bit nave);
        int t0, vcnt;
        l = -1; kills = 0; idx1 = -1; nave = 0; vcnt = 0;
        @(negedge CLOCK_50) inicio_varredura = 1;
        @(negedge CLOCK_50) inicio_varredura = 0;
        t0 = cyc;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLOCK_50);
            if (cyc - t0 == pausa_em) pausa = 1;
            if (cyc - t0 == pausa_em + pausa_len) pausa = 0;
            inicio_varredura = (cyc - t0 == inicio_em);
            if (acerto_valido) begin
                vcnt++;
                if (vcnt == 1) begin
                    kills++;
                    if (kills == 1) idx1 = int'(acerto_indice);
                end
                acerto_ack = vcnt >= ack_delay;
            end else begin
                vcnt = 0;
                acerto_ack = 0;
            end
            if (varredura_fim) begin
                l = cyc - t0;
                nave = nave_atingida;
                break;
            end
        end
        inicio_varredura = 0;
        pausa = 0;
        acerto_ack = 0;
        @(negedge CLOCK_50);
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        reset = 0;
        verifica("rst_valido", acerto_valido, 0);
        verifica("rst_fim", varredura_fim, 0);
        verifica("rst_nave", nave_atingida, 0);
        verifica("rst_ocupado", ocupado, 0);
        verifica("rst_pontos", pontos, 0);
        verifica("rst_indice", acerto_indice, 0);
        // stray ack while nothing is pending
        acerto_ack = 1;
        @(negedge CLOCK_50) acerto_ack = 0;
        verifica("ack_ocioso_pontos", pontos, 0);

        varre(1, -10, 0, -10, lat, nk, fi, ns);
        verifica("t1_lat", lat, 21);
        verifica("t1_kills", nk, 0);
        verifica("t1_pontos", pontos, 0);
        verifica("t1_ocupado", ocupado, 0);

        set_inimigo(7, 110, 80);
        reg_vivo[7] = 1;
        {bola_nave_x, bola_nave_y, bola_nave_ativa} = {10'd115, 10'd85, 1'b1};
        varre(4, -10, 0, -10, lat, nk, fi, ns);
        verifica("t2_indice", fi, 7);
        verifica("t2_kills", nk, 1);
        verifica("t2_lat", lat, 25);
        verifica("t2_pontos", pontos, 10);

        reg_vivo = '0;
        set_inimigo(3, 100, 50);
        set_inimigo(4, 120, 50);
        reg_vivo[3] = 1;
        reg_vivo[4] = 1;
        {bola_nave_x, bola_nave_y} = {10'd118, 10'd55};
        varre(1, -10, 0, -10, lat, nk, fi, ns);
        verifica("t3_indice", fi, 3);
        verifica("t3_kills", nk, 1);
        verifica("t3_lat", lat, 22);
        verifica("t3_pontos", pontos, 20);

        reg_vivo = '0;
        bola_nave_ativa = 0;
        reg_x_bola[120 +: 10] = 10'd510;
        reg_y_bola[120 +: 10] = 10'd402;
        varre(1, -10, 0, -10, lat, nk, fi, ns);
        verifica("t4_nave", ns, 1);
        verifica("t4_lat", lat, 21);
        reg_y_bola[120 +: 10] = 10'd0;
        varre(1, -10, 0, -10, lat, nk, fi, ns);
        verifica("t4_sem_bola", ns, 0);

        varre(1, 3, 5, 12, lat, nk, fi, ns);
        verifica("t5_lat_pausa", lat, 26);
        repeat (30) begin
            @(negedge CLOCK_50);
            if (varredura_fim || ocupado) break;
        end
        verifica("t5_start_ignorado", {varredura_fim, ocupado}, 0);

        @(negedge CLOCK_50) force dut.pontos = 16'hFFFA;
        @(negedge CLOCK_50) release dut.pontos;
        reg_vivo[7] = 1;
        {bola_nave_x, bola_nave_y, bola_nave_ativa} = {10'd115, 10'd85, 1'b1};
        varre(1, -10, 0, -10, lat, nk, fi, ns);
        verifica("t6_satura", pontos, 16'hFFFF);
        varre(2, -10, 0, -10, lat, nk, fi, ns);
        verifica("t6_satura2", pontos, 16'hFFFF);

        @(negedge CLOCK_50) inicio_varredura = 1;
        @(negedge CLOCK_50) inicio_varredura = 0;
        for (int k = 0; k < 40 && !acerto_valido; k++) @(negedge CLOCK_50);
        verifica("t6_espera_valido", acerto_valido, 1);
        reiniciarJogo = 1;
        @(negedge CLOCK_50) reiniciarJogo = 0;
        verifica("t6_reinicio_valido", acerto_valido, 0);
        verifica("t6_reinicio_ocupado", ocupado, 0);
        verifica("t6_reinicio_pontos", pontos, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end
endmodule
